// File: rtl/cordic_pkg.sv
// Shared constants, FSM state type and the quadrant-fold helper for cordic_phase_gen.
package cordic_pkg;

  localparam int PHASE_W = 32;

  // CORDIC gain compensation for a 32-bit datapath (Q2.30).
  localparam logic [31:0] K_32 = 32'h26DD3B6A;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic [PHASE_W-1:0] angle;
    logic               flip;
  } fold_t;

  // round(0.6072529350 * 2^(width-2)), for 2 <= width <= 64.
  function automatic logic [63:0] k_value(input int width);
    return 64'(longint'(0.6072529350 * (2.0 ** (width - 2))));
  endfunction

  // Angles in [90,270) degrees are rotated by 180 so the CORDIC only sees [-90,+90);
  // the rotation is undone by starting from -K instead of +K.
  function automatic fold_t fold(input logic [PHASE_W-1:0] p);
    fold_t f;
    f.flip  = p[PHASE_W-1] ^ p[PHASE_W-2];
    f.angle = f.flip ? (p ^ {1'b1, {(PHASE_W-1){1'b0}}}) : p;
    return f;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, used for phase dither.
module lfsr16
  import cordic_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  output logic [15:0] value,
  output logic [15:0] next_value
);

  logic feedback;

  assign feedback   = value[0] ^ value[2] ^ value[3] ^ value[5];
  assign next_value = {feedback, value[15:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= LFSR_SEED;
    end else if (advance) begin
      value <= next_value;
    end
  end

endmodule

// File: rtl/cordic_phase_gen.sv
// Burst phase accumulator that presents folded angle and initial x/y to a CORDIC.
// Define PHASE_DITHER_EN to add lfsr16 dither (low byte) to the phase before folding.
module cordic_phase_gen
  import cordic_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [15:0]        burst_len,
  input  logic [PHASE_W-1:0] fcw,
  input  logic               fcw_load,
  input  logic [PHASE_W-1:0] phase_ofs,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [PHASE_W-1:0] angle_o,
  output logic [WIDTH-1:0]   x_o,
  output logic [WIDTH-1:0]   y_o,
  output logic               flip,
  output logic               busy,
  output logic               done
);

  localparam logic [WIDTH-1:0] K_POS = WIDTH'(k_value(WIDTH));
  localparam logic [WIDTH-1:0] K_NEG = -K_POS;

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] acc_q, fcw_active_q, acc_next;
  logic [PHASE_W-1:0] phase_base, phase_sum, dither;
  logic [15:0]        count_q, len_q;
  logic               launch, handshake, last_sample;
  fold_t              folded;

  assign launch      = (state_q == IDLE) && start;
  assign handshake   = (state_q == RUN) && out_ready;
  assign last_sample = handshake && (len_q != 16'd0) && (count_q == len_q - 16'd1);
  assign acc_next    = acc_q + fcw_active_q;
  assign phase_base  = launch ? '0 : acc_next;

`ifdef PHASE_DITHER_EN
  logic [15:0] lfsr_value, lfsr_next;

  lfsr16 u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .advance   (handshake),
    .value     (lfsr_value),
    .next_value(lfsr_next)
  );

  // A reloaded sample is shown while the LFSR holds its advanced state.
  assign dither = {24'd0, launch ? lfsr_value[7:0] : lfsr_next[7:0]};
`else
  assign dither = '0;
`endif

  assign phase_sum = phase_base + phase_ofs + dither;
  assign folded    = fold(phase_sum);
  assign y_o       = '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (last_sample) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q        <= '0;
      count_q      <= '0;
      len_q        <= '0;
      fcw_active_q <= '0;
      angle_o      <= '0;
      x_o          <= '0;
      flip         <= 1'b0;
    end else begin
      // A load coinciding with a handshake still advances by the previous word.
      if (fcw_load) fcw_active_q <= fcw;

      if (launch) begin
        acc_q   <= '0;
        count_q <= '0;
        len_q   <= burst_len;
        angle_o <= folded.angle;
        x_o     <= folded.flip ? K_NEG : K_POS;
        flip    <= folded.flip;
      end else if (handshake) begin
        acc_q   <= acc_next;
        count_q <= count_q + 16'd1;
        if (!last_sample) begin
          angle_o <= folded.angle;
          x_o     <= folded.flip ? K_NEG : K_POS;
          flip    <= folded.flip;
        end
      end
    end
  end

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Scoreboard bench for cordic_phase_gen: driver pushes expected samples, negedge monitor pops and compares.
module tb_cordic_phase_gen;

  localparam int          WIDTH = 32;
  localparam logic [31:0] POS_K = 32'h26DD3B6A;
  localparam logic [31:0] NEG_K = 32'hD922C496;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] burst_len;
  logic [31:0] fcw;
  logic        fcw_load;
  logic [31:0] phase_ofs;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] angle_o;
  logic [WIDTH-1:0] x_o;
  logic [WIDTH-1:0] y_o;
  logic        flip;
  logic        busy;
  logic        done;

  cordic_phase_gen #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .burst_len(burst_len),
    .fcw      (fcw),
    .fcw_load (fcw_load),
    .phase_ofs(phase_ofs),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .angle_o  (angle_o),
    .x_o      (x_o),
    .y_o      (y_o),
    .flip     (flip),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int failures  = 0;
  int done_seen = 0;
  int exp_done  = 0;

  // Sample tuple: {angle, x, y, flip}
  logic [96:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference fold: angles in the 2nd and 3rd quadrants are turned by half a revolution.
  function automatic logic [96:0] fold_ref(input logic [31:0] p);
    int unsigned quadrant;
    quadrant = p / 32'h4000_0000;
    if (quadrant == 1 || quadrant == 2) return {p + 32'h8000_0000, NEG_K, 32'd0, 1'b1};
    return {p, POS_K, 32'd0, 1'b0};
  endfunction

  // Monitor
  logic [96:0] held;
  bit          stalled = 1'b0;

  always @(negedge clk) begin
    logic [96:0] cur;
    logic [96:0] e;
    cur = {angle_o, x_o, y_o, flip};
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (done) done_seen++;
      if (stalled && out_valid) check("stall_hold", cur, held);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sample_expected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("sample", cur, e);
        end
      end
      stalled = out_valid && !out_ready;
      held    = cur;
    end
  end

  // ready_mode: 0 always ready, 1 random ready plus stray start pulses, 2 three-cycle stall on sample 2.
  // load_at: handshake number that carries an fcw_load of f1 (0 = none).
  // abort_at: reset after this many handshakes (0 = none). n_cont: handshakes for continuous mode.
  task automatic run_burst(input int len, input logic [31:0] f0, input logic [31:0] ofs,
                           input int ready_mode, input int load_at, input logic [31:0] f1,
                           input int abort_at, input int n_cont);
    logic [31:0] acc_m;
    logic [31:0] fcw_m;
    logic [31:0] prod;
    int          n;
    int          budget;
    int          stall_cnt;
    int          target;
    int          done_before;
    bit          hs;
    bit          busy_ok;
    bit          r;

    @(posedge clk); #1;
    fcw = f0; fcw_load = 1'b1;
    @(posedge clk); #1;
    fcw_load  = 1'b0;
    fcw_m     = f0;
    acc_m     = '0;
    phase_ofs = ofs;
    burst_len = 16'(len);
    n = 0; budget = 0; stall_cnt = 0; busy_ok = 1'b1;
    target = (abort_at != 0) ? abort_at : ((len == 0) ? n_cont : len);
    done_before = done_seen;

    exp_q.push_back(fold_ref(ofs));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    while (n < target && budget < 20 * target + 50) begin
      if (!busy) busy_ok = 1'b0;
      case (ready_mode)
        1: r = 1'($urandom_range(0, 1));
        2: begin
          r = !(n == 1 && stall_cnt < 3);
          if (!r) stall_cnt++;
        end
        default: r = 1'b1;
      endcase
      out_ready = r;
      start     = (ready_mode == 1) && ($urandom_range(0, 7) == 0);
      hs        = out_valid && r;
      if (hs && load_at == n + 1) begin
        fcw = f1; fcw_load = 1'b1;
      end
      @(posedge clk); #1;
      fcw_load = 1'b0;
      start    = 1'b0;
      budget++;
      if (hs) begin
        acc_m = acc_m + fcw_m;
        if (load_at == n + 1) fcw_m = f1;
        n++;
        if (len == 0 || n < len) exp_q.push_back(fold_ref(acc_m + ofs));
      end
    end
    out_ready = 1'b0;
    check("handshakes_done", n, target);
    check("busy_in_run", busy_ok, 1'b1);

    if (abort_at != 0) begin
      rst = 1'b1;
      #1;
      check("reset_outputs", {angle_o, x_o, y_o, flip, out_valid, busy, done}, '0);
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("no_done_after_reset", done_seen, done_before);
      check("idle_after_reset", {out_valid, busy}, 2'b00);
    end else if (len == 0) begin
      prod = 32'(n_cont) * f0;
      check("continuous_acc", {angle_o, x_o, y_o, flip}, fold_ref(prod + ofs));
      check("continuous_no_done", done_seen, done_before);
      check("continuous_busy", busy, 1'b1);
      rst = 1'b1;
      #1;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
    end else begin
      check("done_pulse", {done, out_valid, busy}, 3'b100);
      @(posedge clk); #1;
      check("back_to_idle", {done, out_valid, busy}, 3'b000);
      check("queue_drained", exp_q.size(), 0);
      exp_done++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ofs;
    int          len;
    rst = 1'b1; start = 1'b0; burst_len = '0; fcw = '0; fcw_load = 1'b0;
    phase_ofs = '0; out_ready = 1'b0;
    #1;
    check("reset_state", {angle_o, x_o, y_o, flip, out_valid, busy, done}, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Quadrant sweep
    run_burst(4, 32'h4000_0000, 32'h0, 0, 0, 32'h0, 0, 0);
    // Stall on sample 2
    run_burst(5, $urandom, $urandom, 2, 0, 32'h0, 0, 0);
    // Phase wrap
    run_burst(2, 32'h1, 32'hFFFF_FFFF, 0, 0, 32'h0, 0, 0);
    // fcw_load on 2nd handshake
    run_burst(4, 32'h10, 32'h0, 0, 2, 32'h100, 0, 0);
    // Random bursts with random back-pressure and stray start pulses
    for (int i = 0; i < 4; i++) begin
      len = $urandom_range(1, 12);
      run_burst(len, $urandom, $urandom, 1, $urandom_range(0, len), $urandom, 0, 0);
    end
    // Reset mid-burst, then a fresh burst from the same offset
    ofs = $urandom;
    run_burst(8, $urandom, ofs, 0, 0, 32'h0, 2, 0);
    run_burst(3, $urandom, ofs, 0, 0, 32'h0, 0, 0);
    // Continuous mode
    run_burst(0, $urandom, $urandom, 0, 0, 32'h0, 0, 1000);

    check("done_total", done_seen, exp_done);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cordic_phase_gen.md
CORDIC_PHASE_GEN -- requirements
Module: cordic_phase_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 32, width of x_o/y_o; matches the downstream CORDIC stage count.
REQ-002 SHALL have port clk  input  1  the single clock; all state is on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  pulse; begins a burst.
REQ-005 SHALL have port burst_len  input  16  samples per burst; 0 means continuous.
REQ-006 SHALL have port fcw  input  32  frequency control word, in binary angle units (2^32 = 360°).
REQ-007 SHALL have port fcw_load  input  1  captures fcw.
REQ-008 SHALL have port phase_ofs  input  32  phase offset, binary angle.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the sample.
REQ-010 SHALL have port out_valid  output  1  the sample is valid.
REQ-011 SHALL have port angle_o  output  32  signed folded angle, range [-90°,+90°).
REQ-012 SHALL have port x_o  output  WIDTH  signed initial x: +K or -K.
REQ-013 SHALL have port y_o  output  WIDTH  signed initial y, always 0.
REQ-014 SHALL have port flip  output  1  a 180° pre-rotation was applied.
REQ-015 SHALL have port busy  output  1  the FSM is in RUN.
REQ-016 SHALL have port done  output  1  one-cycle pulse at the end of a burst.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 In IDLE, a start pulse SHALL clear the accumulator, clear the sample count and capture burst_len.
REQ-019 After start is seen in IDLE, the FSM SHALL move to RUN, with out_valid=1 on the next cycle.
REQ-020 The first sample SHALL be fold(0 + phase_ofs).
REQ-021 start SHALL be ignored while in RUN or DONE.
REQ-022 A handshake (out_valid & out_ready) SHALL do all of the following:
  - accumulator += fcw_active, modulo 2^32;
  - count += 1;
  - output registers reload next cycle with fold(acc_new + phase_ofs), phase_ofs sampled at that edge.
REQ-023 While out_valid=1 and out_ready=0, all outputs and the accumulator SHALL hold.
REQ-024 When burst_len≠0 and a handshake completes sample burst_len, the FSM SHALL move RUN→DONE.
REQ-025 In DONE, for one cycle: done=1 and out_valid=0; then DONE→IDLE.
REQ-026 When burst_len=0, RUN SHALL never exit.
REQ-027 fcw_load SHALL update fcw_active in any state.
REQ-028 If fcw_load and a handshake occur in the same cycle, the advance SHALL use the old fcw_active.
REQ-029 fold(p) SHALL be computed as follows:
  - if p[31:30] is 01 or 10: angle_o = p ^ 0x8000_0000, x_o = -K, flip = 1;
  - otherwise: angle_o = p, x_o = +K, flip = 0.
REQ-030 K SHALL equal round(0.6072529350 × 2^(WIDTH-2)); 0x26DD3B6A for WIDTH=32.
REQ-031 busy SHALL be 1 exactly in RUN.

Reset
REQ-032 rst SHALL asynchronously force the following:
  - state IDLE;
  - accumulator, count, fcw_active, angle_o, x_o, y_o = 0;
  - flip, out_valid, busy, done = 0.
REQ-033 Reset mid-burst SHALL abandon the burst with no done pulse.
REQ-034 After rst deasserts, the block SHALL wait for a new start.

Configuration
REQ-035 With PHASE_DITHER_EN defined, before fold, the block SHALL add lfsr[7:0] zero-extended to the phase sum.
REQ-036 The LFSR SHALL be 16-bit, polynomial x^16+x^14+x^13+x^11+1, seed 0xACE1 at reset, advancing once per handshake.
REQ-037 Without PHASE_DITHER_EN, no LFSR logic SHALL exist and the phase SHALL be exact.

Structure
REQ-038 Package cordic_pkg SHALL hold the following:
  - phase width constant (32);
  - the K constant;
  - the FSM state enum;
  - a fold helper function.
REQ-039 The LFSR SHALL be the sub-module lfsr16, instantiated only under PHASE_DITHER_EN.

Verification
REQ-040 Quadrant test. Stimulus: fcw=0x4000_0000, phase_ofs=0, burst_len=4, out_ready=1. Required samples, then done pulse, then IDLE:
  - (0x0000_0000, +K, flip=0);
  - (0xC000_0000, -K, flip=1);
  - (0x0000_0000, -K, flip=1);
  - (0xC000_0000, +K, flip=0).
REQ-041 Stall test: out_ready=0 for 3 cycles in RUN → outputs stable all 3 cycles; the next sample appears only after out_ready=1.
REQ-042 Wrap test: fcw=1, phase_ofs=0xFFFF_FFFF, burst_len=2 → angle_o 0xFFFF_FFFF (flip=0), then 0x0000_0000.
REQ-043 fcw_load test: fcw_load with fcw=0x100 on the 2nd handshake, old fcw=0x10 → accumulator 0x10, 0x20, then 0x120.
REQ-044 Reset test: rst mid-burst at sample 2 of 8 → all outputs reset values; no done pulse; a new start restarts from phase_ofs.
REQ-045 Continuous test: burst_len=0, 1000 handshakes → busy=1 throughout, done never asserts, accumulator = 1000·fcw mod 2^32.
